// File: rtl/write_8piso_pkg.sv
// Shared state encoding and defaults for the 595-style serial writer.
package write_8piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    localparam int NBIT_DEF = 8;
    localparam int DIV_DEF  = 2;
    localparam int TICK_W   = 8;

endpackage

// File: rtl/piso_tick_cnt.sv
// Half-period down-counter: reloads on load_i, saturates at zero, tc_o flags zero.
module piso_tick_cnt
    import write_8piso_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [TICK_W-1:0] load_val_i,
    output logic              tc_o
);

    logic [TICK_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/write_8piso.sv
// Parallel-in, serial-out writer for an external 595-type shift/latch register.
// Outputs are registered from the current state, so they trail the FSM by one cycle.
module write_8piso
    import write_8piso_pkg::*;
#(
    parameter int NBIT = NBIT_DEF,
    parameter int DIV  = DIV_DEF
) (
    input  logic            Clk_I,
    input  logic            Rst_I,
    input  logic [NBIT-1:0] Parl_I,
    input  logic            Load_I,
    output logic            Ready_O,
    output logic            Ser_O,
    output logic            SRClk_O,
    output logic            RClk_O,
    output logic            Done_O
);

    localparam int                BIT_W  = (NBIT > 1) ? $clog2(NBIT) : 1;
    localparam logic [TICK_W-1:0] RELOAD = TICK_W'(DIV - 1);

    state_e            state_q, state_d;
    logic [NBIT-1:0]   sr_q, sr_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              accept, tick_tc, tick_load;
    logic              ready_d, ser_d, srclk_d, rclk_d, done_d;

    assign accept    = Load_I && Ready_O;
    assign tick_load = (state_d != state_q);

    piso_tick_cnt u_tick (
        .clk_i      (Clk_I),
        .rst_i      (Rst_I),
        .load_i     (tick_load),
        .load_val_i (RELOAD),
        .tc_o       (tick_tc)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                sr_d    = Parl_I;
                bit_d   = BIT_W'(NBIT - 1);
                state_d = ST_SETUP;
            end
            ST_SETUP: if (tick_tc) state_d = ST_HIGH;
            ST_HIGH: if (tick_tc) begin
                if (bit_q == '0) begin
                    state_d = ST_LATCH;
                end else begin
                    sr_d    = sr_q << 1;
                    bit_d   = bit_q - 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_LATCH: if (tick_tc) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ser only reloads while in SETUP, so it is frozen across the whole HIGH phase.
    // Done fires on the first IDLE cycle that still sees the trailing latch pulse.
    always_comb begin
        ready_d = (state_q == ST_IDLE) && !accept;
        srclk_d = (state_q == ST_HIGH);
        rclk_d  = (state_q == ST_LATCH);
        ser_d   = (state_q == ST_SETUP) ? sr_q[NBIT-1] : Ser_O;
        done_d  = (state_q == ST_IDLE) && RClk_O;
    end

    always_ff @(posedge Clk_I or posedge Rst_I) begin
        if (Rst_I) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            Ready_O <= 1'b1;
            Ser_O   <= 1'b0;
            SRClk_O <= 1'b0;
            RClk_O  <= 1'b0;
            Done_O  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            Ready_O <= ready_d;
            Ser_O   <= ser_d;
            SRClk_O <= srclk_d;
            RClk_O  <= rclk_d;
            Done_O  <= done_d;
        end
    end

endmodule

// File: tb/tb_write_8piso.sv
// Bench for write_8piso: transfer-level model plus directed scenarios (DIV=2 and DIV=1).
module tb_write_8piso;

    localparam int NBIT = 8;
    localparam int DIV  = 2;
    localparam int LAT  = (2*NBIT + 1)*DIV + 1;

    logic       clk = 1'b0;
    logic       rst, load, load2;
    logic [7:0] parl, parl2;
    logic       ready, ser, srclk, rclk, done;
    logic       ready2, ser2, srclk2, rclk2, done2;

    always #5 clk = ~clk;

    write_8piso #(.NBIT(NBIT), .DIV(DIV)) dut (
        .Clk_I(clk), .Rst_I(rst), .Parl_I(parl), .Load_I(load),
        .Ready_O(ready), .Ser_O(ser), .SRClk_O(srclk), .RClk_O(rclk), .Done_O(done));

    write_8piso #(.NBIT(8), .DIV(1)) dut1 (
        .Clk_I(clk), .Rst_I(rst), .Parl_I(parl2), .Load_I(load2),
        .Ready_O(ready2), .Ser_O(ser2), .SRClk_O(srclk2), .RClk_O(rclk2), .Done_O(done2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transfer model: acceptance when idle and requested, completion LAT edges later.
    int   cnt = 0;
    logic m_ready = 1'b1, m_done = 1'b0;
    bit   m_busy = 0;
    int   done_at = 0, last_acc = 0;
    bit   exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 1'b1; m_done = 1'b0; m_busy = 0;
            exp_q.delete();
        end else begin
            cnt++;
            m_done = 1'b0;
            if (m_busy && cnt == done_at) begin
                m_busy = 0; m_ready = 1'b1; m_done = 1'b1;
            end else if (m_ready && load) begin
                m_busy = 1; m_ready = 1'b0;
                done_at = cnt + LAT; last_acc = cnt;
                for (int i = NBIT-1; i >= 0; i--) exp_q.push_back(parl[i]);
            end
        end
    end

    logic [15:0] got_bits;
    int   rises, rclk_cnt, done_cnt, done_cyc, first_done, gap, rclk_run;
    logic srclk_p = 1'b0, rclk_p = 1'b0, ser_at_rise = 1'b0;

    always @(negedge clk) begin
        chk("ready", ready, m_ready);
        chk("done", done, m_done);
        if (rst) chk("reset_outs", {ser, srclk, rclk}, 3'b000);
        if (srclk && !srclk_p) begin
            got_bits = {got_bits[14:0], ser};
            rises++;
            ser_at_rise = ser;
            if (first_done >= 0 && gap < 0) gap = cnt - first_done;
            if (exp_q.size() == 0) chk("ser_unexpected_rise", 1, 0);
            else chk("ser_bit", ser, exp_q.pop_front());
        end else if (srclk && srclk_p) begin
            chk("ser_stable_high", ser, ser_at_rise);
        end
        if (rclk && !rclk_p) begin
            rclk_cnt++;
            rclk_run = 0;
            chk("bits_left_at_latch", exp_q.size(), 0);
        end
        if (rclk) rclk_run++;
        if (!rclk && rclk_p && !rst) chk("rclk_width", rclk_run, DIV);
        if (done) begin
            done_cnt++;
            done_cyc = cnt;
            if (first_done < 0) first_done = cnt;
        end
        srclk_p = srclk;
        rclk_p  = rclk;
    end

    task automatic clr();
        got_bits = '0; rises = 0; rclk_cnt = 0; done_cnt = 0;
        done_cyc = -1; first_done = -1; gap = -1;
    endtask

    logic [7:0] bits2;
    int r2, h2, dk, a;
    logic p2;

    initial begin
        rst = 1'b1; load = 1'b0; load2 = 1'b0; parl = '0; parl2 = '0;
        clr();
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_outs", {ser, srclk, rclk, done}, 4'b0000);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // A5 single transfer
        clr();
        parl = 8'hA5; load = 1'b1;
        @(posedge clk); #2 load = 1'b0; a = last_acc;
        repeat (45) @(posedge clk); #2;
        chk("a5_bits", got_bits[7:0], 8'hA5);
        chk("a5_rises", rises, 8);
        chk("a5_rclk", rclk_cnt, 1);
        chk("a5_done_cnt", done_cnt, 1);
        chk("a5_latency", done_cyc - a, 35);

        // 0F with an ignored request mid-transfer
        clr();
        parl = 8'h0F; load = 1'b1;
        @(posedge clk); #2 load = 1'b0;
        repeat (9) @(posedge clk); #2 parl = 8'hFF; load = 1'b1;
        @(posedge clk); #2 load = 1'b0;
        repeat (40) @(posedge clk); #2;
        chk("0f_bits", got_bits[7:0], 8'h0F);
        chk("0f_rises", rises, 8);
        chk("0f_done_cnt", done_cnt, 1);

        // Back-to-back with Load held high
        clr();
        parl = 8'h01; load = 1'b1;
        @(posedge clk); #2 parl = 8'h80;
        repeat (36) @(posedge clk); #2 load = 1'b0;
        repeat (40) @(posedge clk); #2;
        chk("b2b_bits", got_bits, 16'h0180);
        chk("b2b_rises", rises, 16);
        chk("b2b_rclk", rclk_cnt, 2);
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_gap", gap, DIV + 2);

        // Reset mid-transfer, then reset together with Load
        clr();
        parl = 8'hC3; load = 1'b1;
        @(posedge clk); #2 load = 1'b0;
        repeat (9) @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("abort_ready", ready, 1'b1);
        chk("abort_outs", {ser, srclk, rclk, done}, 4'b0000);
        load = 1'b1;
        @(posedge clk); #2 rst = 1'b0; load = 1'b0;
        chk("rst_load_ready", ready, 1'b1);
        repeat (45) @(posedge clk); #2;
        chk("abort_rclk", rclk_cnt, 0);
        chk("abort_done", done_cnt, 0);
        chk("abort_rises_partial", rises < 8, 1);

        // DIV=1 instance
        chk("d1_ready", ready2, 1'b1);
        parl2 = 8'h3C; load2 = 1'b1;
        @(posedge clk); #1 load2 = 1'b0;
        bits2 = '0; r2 = 0; h2 = 0; dk = -1; p2 = srclk2;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            if (srclk2 && !p2) begin bits2 = {bits2[6:0], ser2}; r2++; end
            if (srclk2) h2++;
            if (done2 && dk < 0) dk = k;
            p2 = srclk2;
        end
        chk("d1_bits", bits2, 8'h3C);
        chk("d1_rises", r2, 8);
        chk("d1_high_cycles", h2, 8);
        chk("d1_latency", dk, 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_8piso.md
WRITE_8PISO -- requirements
Module: write_8piso

Interface
REQ-001 Parameter NBIT, default 8: number of bits shifted per transfer.
REQ-002 Parameter DIV, default 2: Clk_I cycles per half-period of SRClk_O and per RClk_O pulse; legal values 1..255.
REQ-003 Clk_I  input  1  the single clock; all state changes on rising edge.
REQ-004 Rst_I  input  1  reset, asynchronous, active-high.
REQ-005 Parl_I  input  NBIT  parallel byte to transmit, sampled only on acceptance.
REQ-006 Load_I  input  1  request; a transfer is accepted on a rising edge where Load_I=1 and Ready_O=1.
REQ-007 Ready_O  output  1  high when idle and able to accept.
REQ-008 Ser_O  output  1  serial data to the external 595-type shift register, MSB first.
REQ-009 SRClk_O  output  1  shift clock; external device samples Ser_O on its rising edge.
REQ-010 RClk_O  output  1  storage-latch clock; one pulse per completed transfer.
REQ-011 Done_O  output  1  one-cycle pulse marking transfer completion.

Function
REQ-012 The block SHALL implement FSM states IDLE, SETUP, HIGH, LATCH; all outputs registered.
REQ-013 IDLE: Ready_O=1, SRClk_O=0, RClk_O=0; on acceptance, the block SHALL capture Parl_I into the shift register, set bit counter to NBIT-1, and go to SETUP.
REQ-014 SETUP: Ser_O = shift register MSB, SRClk_O=0, for DIV cycles, then go to HIGH.
REQ-015 HIGH: SRClk_O=1, Ser_O held, for DIV cycles; then, if bit counter = 0, go to LATCH, else shift left by one, decrement counter, go to SETUP.
REQ-016 Ser_O SHALL change only on entry to SETUP, never while SRClk_O=1.
REQ-017 LATCH: SRClk_O=0, RClk_O=1 for DIV cycles, then return to IDLE with Done_O=1 for exactly one cycle.
REQ-018 Latency: Done_O and Ready_O SHALL go high in the cycle starting (2*NBIT+1)*DIV+1 rising edges after the acceptance edge (35 for defaults, 18 for DIV=1).
REQ-019 Exactly NBIT SRClk_O rising edges and one RClk_O pulse SHALL occur per accepted transfer.
REQ-020 Load_I while Ready_O=0 SHALL be ignored with no queuing; Parl_I changes during a transfer SHALL have no effect.
REQ-021 Back-to-back: Load_I=1 in the Done_O cycle SHALL be accepted on that edge; the next SETUP follows immediately with no idle cycle.
REQ-022 Half-period counter SHALL be 8 bits and reload to DIV-1 on each state entry; no wrap occurs for legal DIV.

Reset
REQ-023 Rst_I=1 SHALL asynchronously force state IDLE, Ready_O=1, Ser_O=0, SRClk_O=0, RClk_O=0, Done_O=0, shift register and counters 0.
REQ-024 Reset mid-transfer SHALL abort without generating an RClk_O pulse, so the external storage register keeps its previous value.
REQ-025 Rst_I and Load_I high together SHALL result in no acceptance.

Structure
REQ-026 FSM state encoding and NBIT/DIV defaults SHALL live in shared package write_8piso_pkg.
REQ-027 The half-period counter SHALL be a sub-module named piso_tick_cnt (load, count, terminal-count output); all other logic stays in write_8piso.

Verification
REQ-028 Reset, Parl_I=8'hA5, Load_I for 1 cycle -> Ser_O at the 8 SRClk_O rises = 1,0,1,0,0,1,0,1; one RClk_O pulse of 2 cycles; Done_O 35 cycles after acceptance.
REQ-029 Accept 8'h0F, then Load_I=1 with Parl_I=8'hFF at cycle 10 -> ignored; shifted bits 0,0,0,0,1,1,1,1; single Done_O.
REQ-030 Load_I held high, Parl_I=8'h01 then 8'h80 after first acceptance -> 16 SRClk_O rises, 2 RClk_O pulses, second SETUP directly after first Done_O cycle.
REQ-031 Accept 8'hC3, assert Rst_I at cycle 10 -> all outputs 0 and Ready_O=1 immediately, no RClk_O pulse ever for that transfer.
REQ-032 DIV=1, Parl_I=8'h3C -> SRClk_O high/low 1 cycle each, bits 0,0,1,1,1,1,0,0, Done_O 18 cycles after acceptance.
